// File: rtl/fsm_1011.sv
// Moore detector for the serial pattern "1011" with non-overlapping matches.
// y is a pure decode of the state register and is high for one cycle per match.
module fsm_1011 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic y
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = din ? S1 : S0;
            S1:      state_d = din ? S1 : S2;
            S2:      state_d = din ? S3 : S0;
            // "1010" keeps its trailing "10" as progress
            S3:      state_d = din ? S4 : S2;
            // After a match only the next bit may start a new pattern
            S4:      state_d = din ? S1 : S0;
            default: state_d = S0;
        endcase
    end

    always_comb begin
        y = (state_q == S4);
    end

endmodule

// File: tb/tb_fsm_1011.sv
// Self-checking bench for fsm_1011: directed sequences plus random bits and
// random asynchronous resets, compared against a bit-history reference model.
module tb_fsm_1011;

    logic clk;
    logic rst;
    logic din;
    logic y;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits seen since reset or since the last match
    int       m_cnt;
    logic [3:0] m_hist;

    fsm_1011 u_dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got y=%b expected y=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_hist = 4'b0000;
    endtask

    // Apply one bit, update the model, and return the model's expected y.
    task automatic step(input string tag, input logic b, output logic exp);
        din = b;
        @(posedge clk);
        #1;
        m_hist = {m_hist[2:0], b};
        if (m_cnt < 4) m_cnt++;
        exp = (m_cnt >= 4) && (m_hist == 4'b1011);
        if (exp) model_clear();
        check_eq(tag, y, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_async", y, 1'b0);
        for (int i = 0; i < 2; i++) begin
            din = ~din;
            @(posedge clk);
            #1;
            check_eq("rst_hold", y, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Bits applied MSB-first from bits[n-1]; mask gives the required y after each bit.
    task automatic run_vec(input string tag, input int n, input logic [15:0] bits,
                           input logic [15:0] mask);
        logic e;
        for (int i = n - 1; i >= 0; i--) begin
            step(tag, bits[i], e);
            check_eq(tag, y, mask[i]);
        end
    endtask

    initial begin
        logic e;
        rst = 1'b1;
        din = 1'b0;
        model_clear();
        #1;
        check_eq("por", y, 1'b0);

        do_reset();
        run_vec("basic", 5, 16'b10110, 16'b00010);

        // Asynchronous reset while y is high
        do_reset();
        run_vec("pre_async", 4, 16'b1011, 16'b0001);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_drop", y, 1'b0);
        @(posedge clk);
        #1;
        check_eq("async_hold", y, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        // Mid-pattern reset discards progress
        run_vec("mid_pre", 3, 16'b101, 16'b000);
        do_reset();
        run_vec("mid_post", 4, 16'b1011, 16'b0001);

        do_reset();
        run_vec("repeat", 13, 16'b1011010110110, 16'b0001000010000);
        do_reset();
        run_vec("nonovl", 7, 16'b1011011, 16'b0001000);
        do_reset();
        run_vec("prefix_a", 5, 16'b11011, 16'b00001);
        do_reset();
        run_vec("prefix_b", 6, 16'b101011, 16'b000001);
        do_reset();
        run_vec("fresh", 8, 16'b10111011, 16'b00010001);

        // Random bits with occasional asynchronous reset pulses between edges
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check_eq("rnd_rst", y, 1'b0);
                @(negedge clk);
                rst = 1'b0;
                model_clear();
            end else begin
                // Bias toward 1s so full matches occur often
                step("rnd", ($urandom_range(0, 9) < 6), e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
